// File: rtl/fp_operand_unpacker_if.sv
// rtl/fp_operand_unpacker_if.sv - operand/handshake bundle between the FPU issue logic and the unpacker
//
// Purpose: carries the packed operands and start/result handshake into the
// unpacker, and the decoded sign/exponent/fraction fields, class flags and
// issue/timeout pulses back out.
// Modports:
//   master - the requester/arithmetic side: drives start_i, x_i, y_i,
//            result_valid_i; observes every *_o signal.
//   slave  - the unpacker itself.
interface fp_operand_unpacker_if;
  logic        start_i;
  logic [31:0] x_i;
  logic [31:0] y_i;
  logic        result_valid_i;
  logic        ready_o;
  logic        data_valid_o;
  logic        x_sign_o;
  logic        y_sign_o;
  logic [7:0]  x_exp_o;
  logic [7:0]  y_exp_o;
  logic [22:0] x_frac_o;
  logic [22:0] y_frac_o;
  logic        x_infinity_o;
  logic        y_infinity_o;
  logic        x_nan_o;
  logic        y_nan_o;
  logic        x_zero_o;
  logic        y_zero_o;
  logic        x_subnormal_o;
  logic        y_subnormal_o;
  logic        timeout_o;

  modport master (
    output start_i, x_i, y_i, result_valid_i,
    input  ready_o, data_valid_o, x_sign_o, y_sign_o, x_exp_o, y_exp_o,
           x_frac_o, y_frac_o, x_infinity_o, y_infinity_o, x_nan_o, y_nan_o,
           x_zero_o, y_zero_o, x_subnormal_o, y_subnormal_o, timeout_o
  );

  modport slave (
    input  start_i, x_i, y_i, result_valid_i,
    output ready_o, data_valid_o, x_sign_o, y_sign_o, x_exp_o, y_exp_o,
           x_frac_o, y_frac_o, x_infinity_o, y_infinity_o, x_nan_o, y_nan_o,
           x_zero_o, y_zero_o, x_subnormal_o, y_subnormal_o, timeout_o
  );
endinterface

// File: rtl/fp_operand_unpacker.sv
// rtl/fp_operand_unpacker.sv - IEEE-754 single-precision operand unpacker and classifier ahead of the multiplier
//
// Purpose: accepts an operand pair on start_i while ready_o, splits each into
// sign/exponent/fraction, classifies it (zero, subnormal, infinity, NaN),
// issues a one-cycle data_valid_o pulse and holds the fields until the
// arithmetic unit returns result_valid_i or the watchdog expires.
// Ports:
//   clk_i  - clock
//   rst_i  - asynchronous active-high reset
//   bus    - fp_operand_unpacker_if.slave (operands, handshake, fields, flags)
// Parameters:
//   TIMEOUT_CYCLES - WAIT cycles before the watchdog aborts (2..255)
// Build option:
//   FP_UNPACK_FTZ_EN - when defined, subnormal operands are flushed to zero
//                      (sign kept, exp/frac cleared, zero and subnormal flags set)
module fp_operand_unpacker #(
  parameter int TIMEOUT_CYCLES = 8
) (
  input logic                 clk_i,
  input logic                 rst_i,
  fp_operand_unpacker_if.slave bus
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LIMIT_M1 = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, CLASSIFY, ISSUE, WAIT} state_t;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] frac;
    logic        nan;
    logic        inf;
    logic        zero;
    logic        sub;
  } fields_t;

  function automatic fields_t decode(input logic [31:0] v);
    fields_t f;
    f.sign = v[31];
    f.exp  = v[30:23];
    f.frac = v[22:0];
    f.nan  = (&v[30:23]) && (|v[22:0]);
    f.inf  = (&v[30:23]) && !(|v[22:0]);
    f.zero = !(|v[30:23]) && !(|v[22:0]);
    f.sub  = !(|v[30:23]) && (|v[22:0]);
`ifdef FP_UNPACK_FTZ_EN
    // Exponent is already zero for a subnormal; only the fraction needs clearing.
    if (f.sub) begin
      f.frac = '0;
      f.zero = 1'b1;
    end
`endif
    return f;
  endfunction

  state_t        r_state;
  logic [31:0]   r_x;
  logic [31:0]   r_y;
  logic [CW-1:0] r_cnt;
  fields_t       r_xd;
  fields_t       r_yd;
  logic          r_dv;
  logic          r_to;

  fields_t w_xd;
  fields_t w_yd;

  assign w_xd = decode(r_x);
  assign w_yd = decode(r_y);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= IDLE;
      r_x     <= '0;
      r_y     <= '0;
      r_cnt   <= '0;
      r_xd    <= '0;
      r_yd    <= '0;
      r_dv    <= 1'b0;
      r_to    <= 1'b0;
    end else begin
      r_dv <= 1'b0;
      r_to <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.start_i) begin
            r_x     <= bus.x_i;
            r_y     <= bus.y_i;
            r_state <= CLASSIFY;
          end
        end
        CLASSIFY: begin
          // Fields land on this edge so they are valid alongside the issue pulse.
          r_xd    <= w_xd;
          r_yd    <= w_yd;
          r_dv    <= 1'b1;
          r_state <= ISSUE;
        end
        ISSUE: begin
          r_cnt   <= '0;
          r_state <= WAIT;
        end
        WAIT: begin
          if (bus.result_valid_i) begin
            // A result arriving on the limit cycle takes priority over the abort.
            r_state <= IDLE;
          end else begin
            r_cnt <= r_cnt + CW'(1);
            if (r_cnt == LIMIT_M1) begin
              r_to    <= 1'b1;
              r_state <= IDLE;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.ready_o       = (r_state == IDLE);
  assign bus.data_valid_o  = r_dv;
  assign bus.timeout_o     = r_to;
  assign bus.x_sign_o      = r_xd.sign;
  assign bus.x_exp_o       = r_xd.exp;
  assign bus.x_frac_o      = r_xd.frac;
  assign bus.x_nan_o       = r_xd.nan;
  assign bus.x_infinity_o  = r_xd.inf;
  assign bus.x_zero_o      = r_xd.zero;
  assign bus.x_subnormal_o = r_xd.sub;
  assign bus.y_sign_o      = r_yd.sign;
  assign bus.y_exp_o       = r_yd.exp;
  assign bus.y_frac_o      = r_yd.frac;
  assign bus.y_nan_o       = r_yd.nan;
  assign bus.y_infinity_o  = r_yd.inf;
  assign bus.y_zero_o      = r_yd.zero;
  assign bus.y_subnormal_o = r_yd.sub;

endmodule

// File: tb/tb_fp_operand_unpacker.sv
// tb/tb_fp_operand_unpacker.sv - scoreboard bench for fp_operand_unpacker
module tb_fp_operand_unpacker;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] frac;
    logic        nan;
    logic        inf;
    logic        zero;
    logic        sub;
  } fields_t;

  typedef struct packed {
    fields_t x;
    fields_t y;
  } pair_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_vec = 0;
  int   n_miss = 0;
  pair_t sb[$];
  pair_t last_exp;

  fp_operand_unpacker_if ifc ();

  fp_operand_unpacker #(.TIMEOUT_CYCLES(8)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (ifc.slave)
  );

  always #5 clk = ~clk;

  function automatic fields_t mk(input logic s, input logic [7:0] e, input logic [22:0] f,
                                 input logic nan, input logic inf, input logic zero, input logic sub);
    fields_t r;
    r.sign = s; r.exp = e; r.frac = f; r.nan = nan; r.inf = inf; r.zero = zero; r.sub = sub;
    return r;
  endfunction

  function automatic fields_t get_x();
    return {ifc.x_sign_o, ifc.x_exp_o, ifc.x_frac_o, ifc.x_nan_o, ifc.x_infinity_o, ifc.x_zero_o, ifc.x_subnormal_o};
  endfunction

  function automatic fields_t get_y();
    return {ifc.y_sign_o, ifc.y_exp_o, ifc.y_frac_o, ifc.y_nan_o, ifc.y_infinity_o, ifc.y_zero_o, ifc.y_subnormal_o};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: every issue pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && ifc.data_valid_o) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_miss++;
        $display("FAIL unexpected_issue: got data_valid_o=1 expected no pulse");
      end else begin
        pair_t e;
        e = sb.pop_front();
        chk("x_fields", 64'(get_x()), 64'(e.x));
        chk("y_fields", 64'(get_y()), 64'(e.y));
      end
    end
  end

  // Drive a start in IDLE and step to the ISSUE cycle, checking the 2-cycle latency.
  task automatic do_issue(input logic [31:0] x, input logic [31:0] y, input fields_t ex, input fields_t ey);
    pair_t p;
    @(negedge clk);
    chk("ready_before_start", 64'(ifc.ready_o), 64'd1);
    ifc.x_i = x;
    ifc.y_i = y;
    ifc.start_i = 1'b1;
    p.x = ex;
    p.y = ey;
    sb.push_back(p);
    last_exp = p;
    @(negedge clk);
    ifc.start_i = 1'b0;
    chk("dv_in_classify", 64'(ifc.data_valid_o), 64'd0);
    @(negedge clk);
    chk("dv_in_issue", 64'(ifc.data_valid_o), 64'd1);
  endtask

  // From the ISSUE cycle: wait n cycles, pulse result_valid_i, expect IDLE next cycle.
  task automatic finish_result(input int n);
    repeat (n) @(negedge clk);
    chk("x_hold", 64'(get_x()), 64'(last_exp.x));
    ifc.result_valid_i = 1'b1;
    @(negedge clk);
    ifc.result_valid_i = 1'b0;
    chk("ready_after_result", 64'(ifc.ready_o), 64'd1);
    chk("no_timeout_on_result", 64'(ifc.timeout_o), 64'd0);
  endtask

  fields_t x3;

  initial begin
    ifc.start_i = 1'b0;
    ifc.x_i = '0;
    ifc.y_i = '0;
    ifc.result_valid_i = 1'b0;
    #1 rst = 1'b1;
    #2;
    chk("reset_ready", 64'(ifc.ready_o), 64'd1);
    chk("reset_outputs", {ifc.data_valid_o, ifc.timeout_o, 64'(get_x()), 64'(get_y())} == '0 ? 64'd0 : 64'd1, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Result pulse in IDLE must be ignored.
    ifc.result_valid_i = 1'b1;
    @(negedge clk);
    ifc.result_valid_i = 1'b0;
    chk("idle_result_ignored", 64'(ifc.ready_o), 64'd1);

    // Normal operands: 1.5 and 2.0
    do_issue(32'h3FC00000, 32'h40000000,
             mk(0, 8'h7F, 23'h400000, 0, 0, 0, 0), mk(0, 8'h80, 23'h0, 0, 0, 0, 0));
    finish_result(4);

    // Infinity and quiet NaN
    do_issue(32'h7F800000, 32'h7FC00000,
             mk(0, 8'hFF, 23'h0, 0, 1, 0, 0), mk(0, 8'hFF, 23'h400000, 1, 0, 0, 0));
    finish_result(1);

    // Smallest negative subnormal and +0
`ifdef FP_UNPACK_FTZ_EN
    x3 = mk(1, 8'h00, 23'h0, 0, 0, 1, 1);
`else
    x3 = mk(1, 8'h00, 23'h1, 0, 0, 0, 1);
`endif
    do_issue(32'h80000001, 32'h00000000, x3, mk(0, 8'h00, 23'h0, 0, 0, 1, 0));
    finish_result(2);

    // Watchdog: 8 WAIT cycles follow ISSUE, timeout_o shows in the next one.
    do_issue(32'h40400000, 32'hFF800001,
             mk(0, 8'h80, 23'h400000, 0, 0, 0, 0), mk(1, 8'hFF, 23'h1, 1, 0, 0, 0));
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      chk($sformatf("wait%0d_no_timeout", k), {63'd0, ifc.timeout_o} | {62'd0, ifc.ready_o, 1'b0}, 64'd0);
    end
    @(negedge clk);
    chk("timeout_pulse", 64'(ifc.timeout_o), 64'd1);
    chk("timeout_ready", 64'(ifc.ready_o), 64'd1);
    @(negedge clk);
    chk("timeout_one_cycle", 64'(ifc.timeout_o), 64'd0);
    chk("ready_after_timeout", 64'(ifc.ready_o), 64'd1);

    // Result on the limit cycle wins over the abort.
    do_issue(32'h3FC00000, 32'h40000000,
             mk(0, 8'h7F, 23'h400000, 0, 0, 0, 0), mk(0, 8'h80, 23'h0, 0, 0, 0, 0));
    finish_result(8);
    @(negedge clk);
    chk("limit_result_no_timeout", 64'(ifc.timeout_o), 64'd0);

    // Busy rejection, then acceptance in the IDLE cycle entered from WAIT.
    do_issue(32'h3FC00000, 32'h40000000,
             mk(0, 8'h7F, 23'h400000, 0, 0, 0, 0), mk(0, 8'h80, 23'h0, 0, 0, 0, 0));
    ifc.start_i = 1'b1;
    ifc.x_i = 32'h40400000;
    ifc.y_i = 32'hC1200000;
    repeat (3) begin
      @(negedge clk);
      chk("busy_ready", 64'(ifc.ready_o), 64'd0);
    end
    chk("busy_x_unchanged", 64'(get_x()), 64'(last_exp.x));
    ifc.result_valid_i = 1'b1;
    begin
      pair_t p;
      p.x = mk(0, 8'h80, 23'h400000, 0, 0, 0, 0);
      p.y = mk(1, 8'h82, 23'h200000, 0, 0, 0, 0);
      sb.push_back(p);
      last_exp = p;
    end
    @(negedge clk);
    ifc.result_valid_i = 1'b0;
    chk("ready_back_from_wait", 64'(ifc.ready_o), 64'd1);
    @(negedge clk);
    ifc.start_i = 1'b0;
    chk("requeue_classify", 64'(ifc.data_valid_o), 64'd0);
    @(negedge clk);
    chk("requeue_issue", 64'(ifc.data_valid_o), 64'd1);
    finish_result(2);

    // Asynchronous reset in the middle of WAIT.
    do_issue(32'h7F800000, 32'h7FC00000,
             mk(0, 8'hFF, 23'h0, 0, 1, 0, 0), mk(0, 8'hFF, 23'h400000, 1, 0, 0, 0));
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async_reset_ready", 64'(ifc.ready_o), 64'd1);
    chk("async_reset_outputs", {ifc.data_valid_o, ifc.timeout_o, 64'(get_x()), 64'(get_y())} == '0 ? 64'd0 : 64'd1, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    begin
      int pulses;
      pulses = 0;
      repeat (12) begin
        @(negedge clk);
        if (ifc.data_valid_o || ifc.timeout_o) pulses++;
      end
      chk("pulses_after_reset", 64'(pulses), 64'd0);
    end

    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: got no finish expected finish before 100000");
    $fatal(1);
  end

endmodule
